// File: rtl/modadd_pkg.sv
// modadd_pkg: shared types and helpers for the pipelined modular adder.
package modadd_pkg;

    typedef struct packed {
        logic ff_in;
        logic ff_add;
        logic ff_out;
    } modadd_params_t;

    function automatic int modadd_lat(input modadd_params_t p);
        return int'(p.ff_in) + int'(p.ff_add) + int'(p.ff_out);
    endfunction

    function automatic int modadd_w(input int logq, input int logqh);
        return logq - logqh;
    endfunction

endpackage

// File: rtl/modadd_stage.sv
// modadd_stage: elastic valid/ready register, or a plain wire-through when EN is 0.
module modadd_stage
    import modadd_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter bit EN    = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    generate
        if (EN) begin : g_reg
            logic             valid;
            logic [WIDTH-1:0] data;
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid <= 1'b0;
                    data  <= '0;
                end else begin
                    if (in_ready) valid <= in_valid;
                    if (in_valid && in_ready) data <= in_data;
                end
            end
            assign in_ready  = !valid || out_ready;
            assign out_valid = valid;
            assign out_data  = data;
        end else begin : g_wire
            assign in_ready  = out_ready;
            assign out_valid = in_valid;
            assign out_data  = in_data;
        end
    endgenerate

endmodule

// File: rtl/modadd_pipe.sv
// modadd_pipe: elastic pipelined C = (A + B) mod q, q = {qH, 0..0, 1}.
// Define MODADD_PIPE_RANGE_CHK_EN to add the sticky range_err output.
module modadd_pipe
    import modadd_pkg::*;
#(
    parameter int LOGQ   = 64,
    parameter int LOGQH  = 47,
    parameter int FF_IN  = 1,
    parameter int FF_ADD = 1,
    parameter int FF_OUT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LOGQ-1:0]  A,
    input  logic [LOGQ-1:0]  B,
    input  logic [LOGQH-1:0] qH,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LOGQ-1:0]  C
`ifdef MODADD_PIPE_RANGE_CHK_EN
    ,
    output logic             range_err
`endif
);

    localparam int W  = modadd_w(LOGQ, LOGQH);
    localparam int PW = 2 * LOGQ + LOGQH;

    logic             v1, r1, v2, r2;
    logic [PW-1:0]    p1;
    logic [LOGQ-1:0]  a1, b1, q1, c_sum, c2;
    logic [LOGQH-1:0] qh1;
    logic [LOGQ:0]    s;
    logic [LOGQ+1:0]  t;

    modadd_stage #(.WIDTH(PW), .EN(FF_IN != 0)) u_in (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data({A, B, qH}),
        .out_valid(v1), .out_ready(r1), .out_data(p1)
    );

    assign {a1, b1, qh1} = p1;
    assign q1    = {qh1, W'(1)};
    assign s     = {1'b0, a1} + {1'b0, b1};
    assign t     = {1'b0, s} - {2'b00, q1};
    // A negative t means the sum was already below q: keep it unreduced.
    assign c_sum = t[LOGQ+1] ? s[LOGQ-1:0] : t[LOGQ-1:0];

    modadd_stage #(.WIDTH(LOGQ), .EN(FF_ADD != 0)) u_add (
        .clk(clk), .rst(rst),
        .in_valid(v1), .in_ready(r1), .in_data(c_sum),
        .out_valid(v2), .out_ready(r2), .out_data(c2)
    );

    modadd_stage #(.WIDTH(LOGQ), .EN(FF_OUT != 0)) u_out (
        .clk(clk), .rst(rst),
        .in_valid(v2), .in_ready(r2), .in_data(c2),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(C)
    );

`ifdef MODADD_PIPE_RANGE_CHK_EN
    logic [LOGQ-1:0] q_in;
    assign q_in = {qH, W'(1)};
    always_ff @(posedge clk) begin
        if (rst) range_err <= 1'b0;
        else if (in_valid && in_ready && (A >= q_in || B >= q_in)) range_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_modadd_pipe.sv
// tb_modadd_pipe: randomized scoreboard bench for modadd_pipe against a plain (A+B)%q model.
module tb_modadd_pipe;

    typedef struct {
        logic [63:0] c;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] A = '0;
    logic [63:0] B = '0;
    logic [46:0] qH = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] C;
`ifdef MODADD_PIPE_RANGE_CHK_EN
    logic        range_err;
`endif

    int   checks = 0, errors = 0, cyc = 0;
    bit   lat_chk = 1'b0, rnd_mode = 1'b0, stalled = 1'b0;
    logic [63:0] held_c;
    exp_t exp_q[$];

    modadd_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .qH(qH),
        .out_valid(out_valid), .out_ready(out_ready), .C(C)
`ifdef MODADD_PIPE_RANGE_CHK_EN
        , .range_err(range_err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        if (rnd_mode) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    function automatic logic [127:0] mod_of(input logic [46:0] qh);
        return ({81'b0, qh} << 17) + 128'd1;
    endfunction

    function automatic logic [63:0] ref_add(input logic [63:0] a, input logic [63:0] b, input logic [46:0] qh);
        logic [127:0] s;
        s = {64'b0, a} + {64'b0, b};
        return 64'(s % mod_of(qh));
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [46:0] qh, output int waits);
        waits = 0;
        in_valid = 1'b1; A = a; B = b; qH = qh;
        @(negedge clk);
        while (!in_ready && waits < 1000) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready stuck low for %0d cycles", waits);
        end else begin
            exp_q.push_back('{ref_add(a, b, qh), cyc});
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1 chk("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: pops the scoreboard on every output transfer and checks stall stability.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_c", C, held_c);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_output: got C=%0d, required no output", C);
                end else begin
                    e = exp_q.pop_front();
                    chk("result_c", C, e.c);
                    if (lat_chk) chk("latency", 64'(cyc - e.cyc), 64'd3);
                end
            end
            stalled = out_valid && !out_ready;
            held_c  = C;
        end
    end

    initial begin
        logic [63:0]  da[4];
        logic [63:0]  db[4];
        logic [127:0] q;
        logic [63:0]  ra, rb;
        logic [46:0]  rq;
        int           w;
        da = '{64'd5, 64'd100000, 64'd131072, 64'd0};
        db = '{64'd7, 64'd50000, 64'd1, 64'd0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_c", C, 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef MODADD_PIPE_RANGE_CHK_EN
        chk("rst_range_err", 64'(range_err), 64'd0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;

        lat_chk = 1'b1;
        for (int i = 0; i < 4; i++) send(da[i], db[i], 47'd1, w);
        drain();

        q = mod_of(47'h7FFF_FFFF_FFFF);
        send(64'(q - 1), 64'(q - 1), 47'h7FFF_FFFF_FFFF, w);
        drain();

        lat_chk = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(64'(i + 10), 64'(i + 20), 47'd3, w);
            chk("bp_accept_wait", 64'(w), 64'd0);
        end
        in_valid = 1'b1; A = 64'd13; B = 64'd23; qH = 47'd3;
        @(negedge clk);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(64'd13, 64'd23, 47'd3, w);
        send(64'd14, 64'd24, 47'd3, w);
        drain();

        send(64'd131073, 64'd0, 47'd1, w);
        drain();
`ifdef MODADD_PIPE_RANGE_CHK_EN
        chk("range_err_set", 64'(range_err), 64'd1);
        send(64'd1, 64'd1, 47'd1, w);
        drain();
        chk("range_err_sticky", 64'(range_err), 64'd1);
`endif

        rnd_mode = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            int gap;
            rq = 47'({$urandom, $urandom});
            q  = mod_of(rq);
            ra = 64'({64'b0, $urandom, $urandom} % q);
            rb = 64'({64'b0, $urandom, $urandom} % q);
            gap = $urandom_range(0, 1);
            if (gap != 0) begin
                @(posedge clk);
                #1;
            end
            send(ra, rb, rq, w);
        end
        rnd_mode = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain();

        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(64'(i + 100), 64'd1, 47'd1, w);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("rst_flush_valid", 64'(out_valid), 64'd0);
`ifdef MODADD_PIPE_RANGE_CHK_EN
        chk("rst_range_clear", 64'(range_err), 64'd0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        lat_chk = 1'b1;
        send(64'd1, 64'd2, 47'd1, w);
        drain();
        repeat (5) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
